// File: rtl/vga_console_writer.sv
// Text-console writer: turns a character stream into cell writes for a
// ROWS x COLS character memory. Handles cursor motion, control codes and
// hardware scrolling through a top_row offset.
module vga_console_writer #(
  parameter int unsigned ROWS   = 29,
  parameter int unsigned COLS   = 69,
  parameter logic [7:0]  BLANK  = 8'h20,
  parameter logic [2:0]  CLR_FG = 3'b111,
  parameter logic [2:0]  CLR_BG = 3'b000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_char,
  input  logic [2:0] in_fg,
  input  logic [2:0] in_bg,
  output logic       we,
  output logic [4:0] wr_addr,
  output logic [6:0] wc_addr,
  output logic [7:0] w_ascii,
  output logic [2:0] w_fg_color,
  output logic [2:0] w_bg_color,
  output logic [4:0] cur_row,
  output logic [6:0] cur_col,
  output logic [4:0] top_row,
  output logic       busy
);

  typedef enum logic [1:0] {S_CLEAR_ALL, S_IDLE, S_CLEAR_LINE} state_t;

  localparam logic [4:0] ROW_MAX = 5'(ROWS - 1);
  localparam logic [6:0] COL_MAX = 7'(COLS - 1);
  localparam logic [5:0] ROWS6   = 6'(ROWS);

  state_t     state_q, state_d;
  logic [4:0] cur_row_q, cur_row_d, top_row_q, top_row_d, clr_row_q, clr_row_d;
  logic [6:0] cur_col_q, cur_col_d, clr_col_q, clr_col_d;
  logic       we_q, we_d;
  logic [4:0] wr_q, wr_d;
  logic [6:0] wc_q, wc_d;
  logic [7:0] asc_q, asc_d;
  logic [2:0] fg_q, fg_d, bg_q, bg_d;
  logic       nl;

  // Logical row to physical row; the sum stays below 2*ROWS so one
  // conditional subtract is enough.
  function automatic logic [4:0] phys(input logic [4:0] top, input logic [4:0] row);
    logic [5:0] s;
    s = {1'b0, top} + {1'b0, row};
    if (s >= ROWS6) s = s - ROWS6;
    return s[4:0];
  endfunction

  // Next-state, cursor and registered write-port decode.
  always_comb begin
    state_d   = state_q;
    cur_row_d = cur_row_q;
    cur_col_d = cur_col_q;
    top_row_d = top_row_q;
    clr_row_d = clr_row_q;
    clr_col_d = clr_col_q;
    we_d      = 1'b0;
    wr_d      = wr_q;
    wc_d      = wc_q;
    asc_d     = asc_q;
    fg_d      = fg_q;
    bg_d      = bg_q;
    nl        = 1'b0;
    case (state_q)
      S_CLEAR_ALL: begin
        we_d  = 1'b1;
        wr_d  = clr_row_q;
        wc_d  = clr_col_q;
        asc_d = BLANK;
        fg_d  = CLR_FG;
        bg_d  = CLR_BG;
        if (clr_col_q == COL_MAX) begin
          clr_col_d = '0;
          if (clr_row_q == ROW_MAX) begin
            clr_row_d = '0;
            state_d   = S_IDLE;
          end else begin
            clr_row_d = clr_row_q + 5'd1;
          end
        end else begin
          clr_col_d = clr_col_q + 7'd1;
        end
      end
      S_CLEAR_LINE: begin
        we_d  = 1'b1;
        wr_d  = clr_row_q;
        wc_d  = clr_col_q;
        asc_d = BLANK;
        fg_d  = CLR_FG;
        bg_d  = CLR_BG;
        if (clr_col_q == COL_MAX) begin
          clr_col_d = '0;
          state_d   = S_IDLE;
        end else begin
          clr_col_d = clr_col_q + 7'd1;
        end
      end
      S_IDLE: begin
        if (in_valid) begin
          if (in_char >= 8'h20 && in_char <= 8'h7E) begin
            we_d  = 1'b1;
            wr_d  = phys(top_row_q, cur_row_q);
            wc_d  = cur_col_q;
            asc_d = in_char;
            fg_d  = in_fg;
            bg_d  = in_bg;
            if (cur_col_q == COL_MAX) begin
              cur_col_d = '0;
              nl        = 1'b1;
            end else begin
              cur_col_d = cur_col_q + 7'd1;
            end
          end else if (in_char == 8'h0A) begin
            cur_col_d = '0;
            nl        = 1'b1;
          end else if (in_char == 8'h0D) begin
            cur_col_d = '0;
          end else if (in_char == 8'h08) begin
            asc_d = BLANK;
            fg_d  = CLR_FG;
            bg_d  = CLR_BG;
            if (cur_col_q != '0) begin
              cur_col_d = cur_col_q - 7'd1;
              we_d      = 1'b1;
              wr_d      = phys(top_row_q, cur_row_q);
              wc_d      = cur_col_q - 7'd1;
            end else if (cur_row_q != '0) begin
              cur_row_d = cur_row_q - 5'd1;
              cur_col_d = COL_MAX;
              we_d      = 1'b1;
              wr_d      = phys(top_row_q, cur_row_q - 5'd1);
              wc_d      = COL_MAX;
            end
          end else if (in_char == 8'h0C) begin
            state_d   = S_CLEAR_ALL;
            cur_row_d = '0;
            cur_col_d = '0;
            top_row_d = '0;
            clr_row_d = '0;
            clr_col_d = '0;
          end
          // A wrapping printable registers its own write this cycle, so the
          // line clear it triggers always starts one cycle later.
          if (nl) begin
            if (cur_row_q < ROW_MAX) begin
              cur_row_d = cur_row_q + 5'd1;
            end else begin
              top_row_d = (top_row_q == ROW_MAX) ? '0 : top_row_q + 5'd1;
              clr_row_d = top_row_q;
              clr_col_d = '0;
              state_d   = S_CLEAR_LINE;
            end
          end
        end
      end
      default: state_d = S_CLEAR_ALL;
    endcase
  end

  // State and output registers; reset restarts a full-screen clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_CLEAR_ALL;
      cur_row_q <= '0;
      cur_col_q <= '0;
      top_row_q <= '0;
      clr_row_q <= '0;
      clr_col_q <= '0;
      we_q      <= 1'b0;
      wr_q      <= '0;
      wc_q      <= '0;
      asc_q     <= '0;
      fg_q      <= '0;
      bg_q      <= '0;
    end else begin
      state_q   <= state_d;
      cur_row_q <= cur_row_d;
      cur_col_q <= cur_col_d;
      top_row_q <= top_row_d;
      clr_row_q <= clr_row_d;
      clr_col_q <= clr_col_d;
      we_q      <= we_d;
      wr_q      <= wr_d;
      wc_q      <= wc_d;
      asc_q     <= asc_d;
      fg_q      <= fg_d;
      bg_q      <= bg_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign busy       = !in_ready;
  assign we         = we_q;
  assign wr_addr    = wr_q;
  assign wc_addr    = wc_q;
  assign w_ascii    = asc_q;
  assign w_fg_color = fg_q;
  assign w_bg_color = bg_q;
  assign cur_row    = cur_row_q;
  assign cur_col    = cur_col_q;
  assign top_row    = top_row_q;

endmodule

// File: tb/tb_vga_console_writer.sv
// Scoreboard bench for vga_console_writer: a console model predicts every
// cell write; a negedge monitor pops and compares each write the DUT makes.
module tb_vga_console_writer;
  localparam int ROWS = 29;
  localparam int COLS = 69;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_char = '0;
  logic [2:0] in_fg = '0, in_bg = '0;
  logic       we;
  logic [4:0] wr_addr, cur_row, top_row;
  logic [6:0] wc_addr, cur_col;
  logic [7:0] w_ascii;
  logic [2:0] w_fg_color, w_bg_color;
  logic       busy;

  vga_console_writer #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_char(in_char), .in_fg(in_fg), .in_bg(in_bg), .we(we),
    .wr_addr(wr_addr), .wc_addr(wc_addr), .w_ascii(w_ascii),
    .w_fg_color(w_fg_color), .w_bg_color(w_bg_color),
    .cur_row(cur_row), .cur_col(cur_col), .top_row(top_row), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] r;
    logic [6:0] c;
    logic [7:0] a;
    logic [2:0] f;
    logic [2:0] b;
  } cell_t;

  cell_t sb[$];
  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int m_row = 0, m_col = 0, m_top = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest predicted cell.
  always @(negedge clk) begin
    if (!rst && we) begin
      cell_t got, exp;
      got = '{r: wr_addr, c: wc_addr, a: w_ascii, f: w_fg_color, b: w_bg_color};
      wr_count++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got r=%0d c=%0d a=%h, expected no write",
                 got.r, got.c, got.a);
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL cell_write: got r=%0d c=%0d a=%h f=%0d b=%0d expected r=%0d c=%0d a=%h f=%0d b=%0d",
                   got.r, got.c, got.a, got.f, got.b, exp.r, exp.c, exp.a, exp.f, exp.b);
        end
      end
    end
  end

  task automatic push_cell(input int r, input int c, input int a, input int f, input int b);
    cell_t x;
    x.r = r[4:0]; x.c = c[6:0]; x.a = a[7:0]; x.f = f[2:0]; x.b = b[2:0];
    sb.push_back(x);
  endtask

  task automatic push_clear_all();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) push_cell(r, c, 8'h20, 7, 0);
  endtask

  // Console model: applies the character rules to the logical cursor.
  task automatic model_accept(input int ch, input int fg, input int bg);
    bit nl = 0;
    if (ch >= 8'h20 && ch <= 8'h7E) begin
      push_cell((m_top + m_row) % ROWS, m_col, ch, fg, bg);
      if (m_col == COLS - 1) begin m_col = 0; nl = 1; end
      else m_col++;
    end else if (ch == 8'h0A) begin
      m_col = 0; nl = 1;
    end else if (ch == 8'h0D) begin
      m_col = 0;
    end else if (ch == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        push_cell((m_top + m_row) % ROWS, m_col, 8'h20, 7, 0);
      end else if (m_row > 0) begin
        m_row--; m_col = COLS - 1;
        push_cell((m_top + m_row) % ROWS, m_col, 8'h20, 7, 0);
      end
    end else if (ch == 8'h0C) begin
      m_row = 0; m_col = 0; m_top = 0;
      push_clear_all();
    end
    if (nl) begin
      if (m_row < ROWS - 1) m_row++;
      else begin
        for (int c = 0; c < COLS; c++) push_cell(m_top, c, 8'h20, 7, 0);
        m_top = (m_top + 1) % ROWS;
      end
    end
  endtask

  task automatic check_cursor(input string tag);
    check({tag, "_row"}, cur_row, m_row);
    check({tag, "_col"}, cur_col, m_col);
    check({tag, "_top"}, top_row, m_top);
  endtask

  // Offer one character (inputs change #1 after a rising edge).
  task automatic send(input int ch, input int fg, input int bg);
    int n = 0;
    in_char = ch[7:0]; in_fg = fg[2:0]; in_bg = bg[2:0]; in_valid = 1'b1;
    while (!in_ready && n < 5000) begin @(posedge clk); #1; n++; end
    if (!in_ready) check("send_timeout", 0, 1);
    @(posedge clk);
    model_accept(ch, fg, bg);
    #1;
    in_valid = 1'b0;
    check_cursor("cursor");
  endtask

  // Count rising edges until in_ready is seen high.
  task automatic wait_ready(input string name, input int exp);
    int n = 0;
    while (!in_ready && n < 5000) begin @(posedge clk); #1; n++; end
    check(name, n, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    check("rst_we", we, 0);
    check("rst_ready", in_ready, 0);
    check("rst_busy", busy, 1);
    m_row = 0; m_col = 0; m_top = 0;
    check_cursor("rst");
    push_clear_all();
    wr_count = 0;
    rst = 1'b0;
  endtask

  initial begin
    int ch, k;
    // Power-on clear.
    do_reset();
    wait_ready("clear_all_len", 2001);
    @(negedge clk); #1;
    check("clear_all_writes", wr_count, 2001);

    // Single printable, then 69 back-to-back from column 0.
    send(8'h41, 2, 1);
    check("A_col", cur_col, 1);
    send(8'h0D, 0, 0);
    for (int i = 0; i < COLS; i++) begin
      check("b2b_ready", in_ready, 1);
      send(8'h42, 3, 4);
    end
    check("wrap_row", cur_row, 1);
    check("wrap_col", cur_col, 0);

    // Backspace across a row boundary, then at home.
    send(8'h08, 0, 0);
    check("bs_col", cur_col, 68);
    send(8'h0C, 0, 0);
    wait_ready("ff_clear_len", 2001);
    send(8'h08, 0, 0);
    check("bs_home_col", cur_col, 0);

    // Scroll from (28,5).
    for (int i = 0; i < ROWS - 1; i++) send(8'h0A, 0, 0);
    for (int i = 0; i < 5; i++) send(8'h78, 5, 2);
    send(8'h0A, 0, 0);
    check("scroll_top", top_row, 1);
    wait_ready("clear_line_len", 69);
    send(8'h43, 6, 3);

    // Printable landing in the last cell of the bottom row.
    send(8'h0D, 0, 0);
    for (int i = 0; i < COLS; i++) send(8'h30 + (i % 10), 1, 6);
    wait_ready("wrap_scroll_len", 69);
    check("wrap_scroll_top", top_row, 2);

    // Reset during a line clear.
    send(8'h0A, 0, 0);
    repeat (10) @(posedge clk);
    #1;
    do_reset();
    wait_ready("rst_line_len", 2001);
    check("rst_line_top", top_row, 0);

    // Reset at write 1000 of the full clear.
    do_reset();
    k = 0;
    while (wr_count < 1000 && k < 5000) begin @(negedge clk); k++; end
    check("reach_1000", wr_count, 1000);
    do_reset();
    wait_ready("rst_mid_len", 2001);
    @(negedge clk); #1;
    check("rst_mid_writes", wr_count, 2001);

    // Randomized traffic.
    @(posedge clk); #1;
    for (int i = 0; i < 600; i++) begin
      k = $urandom_range(0, 99);
      if (k < 70) ch = $urandom_range(8'h20, 8'h7E);
      else if (k < 80) ch = 8'h0A;
      else if (k < 85) ch = 8'h0D;
      else if (k < 93) ch = 8'h08;
      else if (k < 99) begin
        k = $urandom_range(0, 3);
        ch = (k == 0) ? 8'h01 : (k == 1) ? 8'h7F : (k == 2) ? 8'h80 : 8'hFF;
      end else ch = (i % 3 == 0) ? 8'h0C : 8'h41;
      send(ch, $urandom_range(0, 7), $urandom_range(0, 7));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    // Drain outstanding writes.
    k = 0;
    while ((!in_ready || sb.size() != 0) && k < 5000) begin @(negedge clk); k++; end
    repeat (2) @(negedge clk);
    check("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
